// File: rtl/fetch_2_pkg.sv
// ============================================================================
// rv32i_types : shared RV32I fetch-path types (fetch stage registers, states)
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int RV_XLEN = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } fetch_reg_1_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_reg_2_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch2_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_2_if.sv
// ============================================================================
// fetch_2_if : fetch_1 register, imem response and instruction-queue signals
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface fetch_2_if
  import rv32i_types::*;
#(
  parameter int XLEN = 32
);

  fetch_reg_1_t    fetch_1_reg;
  logic            imem_resp;
  logic [XLEN-1:0] imem_rdata;
  logic            branch_mispredict;
  logic            iq_full;
  logic            iq_enq;
  fetch_reg_2_t    iq_entry;
  logic            imem_stall;

  // Environment side: drives fetch_1/imem/backend inputs, observes the queue.
  modport master (
    output fetch_1_reg,
    output imem_resp,
    output imem_rdata,
    output branch_mispredict,
    output iq_full,
    input  iq_enq,
    input  iq_entry,
    input  imem_stall
  );

  modport slave (
    input  fetch_1_reg,
    input  imem_resp,
    input  imem_rdata,
    input  branch_mispredict,
    input  iq_full,
    output iq_enq,
    output iq_entry,
    output imem_stall
  );

endinterface

`default_nettype wire

// File: rtl/fetch_2.sv
// ============================================================================
// fetch_2  : pairs the outstanding fetch PC with the imem word, enqueues it
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_2
  import rv32i_types::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic       clk,
  input  logic       rst,
  fetch_2_if.slave   bus
);

  fetch2_state_t   state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;

  logic            enq;
  logic            stall;
  fetch_reg_2_t    entry;

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    enq         = 1'b0;
    stall       = 1'b0;
    entry       = '{pc: pend_pc_q, inst: bus.imem_rdata};

    case (state_q)
      IDLE: begin
        if (bus.fetch_1_reg.valid) begin
          pend_pc_d = bus.fetch_1_reg.pc;
          state_d   = bus.branch_mispredict ? DROP : WAIT;
        end
      end

      WAIT: begin
        stall = ~bus.imem_resp | bus.iq_full;
        if (bus.branch_mispredict) begin
          state_d = bus.imem_resp ? IDLE : DROP;
        end else if (bus.imem_resp && !bus.iq_full) begin
          enq = 1'b1;
          // A request issued alongside the response keeps us waiting.
          if (bus.fetch_1_reg.valid) begin
            pend_pc_d = bus.fetch_1_reg.pc;
            state_d   = WAIT;
          end else begin
            state_d   = IDLE;
          end
        end else if (bus.imem_resp) begin
          hold_pc_d   = pend_pc_q;
          hold_inst_d = bus.imem_rdata;
          state_d     = HOLD;
        end
      end

      DROP: begin
        stall = 1'b1;
        if (bus.imem_resp) begin
          state_d = IDLE;
        end
      end

      HOLD: begin
        stall = 1'b1;
        entry = '{pc: hold_pc_q, inst: hold_inst_q};
        if (bus.branch_mispredict) begin
          state_d = IDLE;
        end else if (!bus.iq_full) begin
          enq     = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_pc_q   <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Outputs are quiet while reset is asserted, regardless of prior state.
  assign bus.iq_enq     = enq & ~rst;
  assign bus.imem_stall = stall & ~rst;
  assign bus.iq_entry   = entry;

endmodule

`default_nettype wire
